// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
`default_nettype none

package rf_pkg;

  localparam int DATA_W   = 64;
  localparam int ZERO_REG = 31;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

endpackage

`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
// Writeback requesters, register-file write port and both read paths.
`default_nettype none

interface rf_write_arbiter_if #(
  parameter int DATA_W = rf_pkg::DATA_W
);
  import rf_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;

  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              stall1;
  logic              stall2;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  ReadRegister1, ReadRegister2, rf_rd1, rf_rd2,
    output a_ready, b_ready,
    output RegWrite, WriteRegister, WriteData,
    output ReadData1, ReadData2, stall1, stall2
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output ReadRegister1, ReadRegister2, rf_rd1, rf_rd2,
    input  a_ready, b_ready,
    input  RegWrite, WriteRegister, WriteData,
    input  ReadData1, ReadData2, stall1, stall2
  );

endinterface

`default_nettype wire

// File: rtl/rf_write_arbiter_fifo.sv
// Per-requester writeback FIFO with age-ordered address match vectors.
`default_nettype none

module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = rf_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  input  logic [ADDR_W-1:0]          cmp_addr1,
  input  logic [ADDR_W-1:0]          cmp_addr2,
  output logic [DEPTH-1:0]           match1,
  output logic [DEPTH-1:0]           match2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  idx;
  logic              do_push;
  logic              do_pop;

  assign full       = (count == CNT_FULL);
  assign head_valid = (count != '0);
  // A full FIFO refuses the push even when it pops in the same cycle.
  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;
  assign head_addr  = mem_addr[rd_ptr];
  assign head_data  = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bit i flags the valid entry i places behind the head (bit 0 is the head).
  always_comb begin
    match1 = '0;
    match2 = '0;
    idx    = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        match1[i] = (mem_addr[idx] == cmp_addr1);
        match2[i] = (mem_addr[idx] == cmp_addr2);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register-file write port between ALU (A) and
// load (B) writeback, with write-bypass and queued-write hazard stalls.
`default_nettype none

module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ZERO_REG = rf_pkg::ZERO_REG
) (
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0] a_head_addr;
  logic [DATA_W-1:0] a_head_data;
  logic              a_head_valid;
  logic [CNT_W-1:0]  a_count;
  logic              a_full;
  logic [DEPTH-1:0]  a_match1;
  logic [DEPTH-1:0]  a_match2;

  logic [ADDR_W-1:0] b_head_addr;
  logic [DATA_W-1:0] b_head_data;
  logic              b_head_valid;
  logic [CNT_W-1:0]  b_count;
  logic              b_full;
  logic [DEPTH-1:0]  b_match1;
  logic [DEPTH-1:0]  b_match2;

  grant_t            last_grant;
  logic              grant_a;
  logic              grant_b;
  logic [DEPTH-1:0]  a_head_mask;
  logic [DEPTH-1:0]  b_head_mask;

  assign bus.a_ready = (a_count != CNT_FULL);
  assign bus.b_ready = (b_count != CNT_FULL);

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo_a (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.a_valid && !a_full),
    .push_addr  (bus.a_addr),
    .push_data  (bus.a_data),
    .pop        (grant_a),
    .head_addr  (a_head_addr),
    .head_data  (a_head_data),
    .head_valid (a_head_valid),
    .count      (a_count),
    .full       (a_full),
    .cmp_addr1  (bus.ReadRegister1),
    .cmp_addr2  (bus.ReadRegister2),
    .match1     (a_match1),
    .match2     (a_match2)
  );

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo_b (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.b_valid && !b_full),
    .push_addr  (bus.b_addr),
    .push_data  (bus.b_data),
    .pop        (grant_b),
    .head_addr  (b_head_addr),
    .head_data  (b_head_data),
    .head_valid (b_head_valid),
    .count      (b_count),
    .full       (b_full),
    .cmp_addr1  (bus.ReadRegister1),
    .cmp_addr2  (bus.ReadRegister2),
    .match1     (b_match1),
    .match2     (b_match2)
  );

  // Under contention the requester that did not win last time goes next.
  assign grant_a = a_head_valid && (!b_head_valid || (last_grant == GRANT_B));
  assign grant_b = b_head_valid && !grant_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GRANT_B;
    end else if (grant_a) begin
      last_grant <= GRANT_A;
    end else if (grant_b) begin
      last_grant <= GRANT_B;
    end
  end

  // Zero-register heads still occupy their slot and pop, but never write.
  always_comb begin
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = '0;
    bus.WriteData     = '0;
    if (grant_a) begin
      bus.RegWrite      = (a_head_addr != ZERO_ADDR);
      bus.WriteRegister = a_head_addr;
      bus.WriteData     = a_head_data;
    end else if (grant_b) begin
      bus.RegWrite      = (b_head_addr != ZERO_ADDR);
      bus.WriteRegister = b_head_addr;
      bus.WriteData     = b_head_data;
    end
  end

  function automatic logic [DATA_W-1:0] bypass(
    input logic [ADDR_W-1:0] rd_addr,
    input logic [DATA_W-1:0] raw,
    input logic              we,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    if (rd_addr == ZERO_ADDR) begin
      return '0;
    end else if (we && (wr_addr == rd_addr)) begin
      return wr_data;
    end
    return raw;
  endfunction

  assign bus.ReadData1 = bypass(bus.ReadRegister1, bus.rf_rd1, bus.RegWrite,
                                bus.WriteRegister, bus.WriteData);
  assign bus.ReadData2 = bypass(bus.ReadRegister2, bus.rf_rd2, bus.RegWrite,
                                bus.WriteRegister, bus.WriteData);

  // The granted head is already visible through the bypass, so it never stalls.
  assign a_head_mask = {{(DEPTH-1){1'b0}}, grant_a};
  assign b_head_mask = {{(DEPTH-1){1'b0}}, grant_b};

  assign bus.stall1 = (bus.ReadRegister1 != ZERO_ADDR) &&
                      (|(a_match1 & ~a_head_mask) || |(b_match1 & ~b_head_mask));
  assign bus.stall2 = (bus.ReadRegister2 != ZERO_ADDR) &&
                      (|(a_match2 & ~a_head_mask) || |(b_match2 & ~b_head_mask));

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// Directed bench with a queue-based reference of both requester FIFOs.
`default_nettype none

module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(64)) ifc ();

  rf_write_arbiter #(
    .DEPTH    (DEPTH),
    .DATA_W   (64),
    .ZERO_REG (31)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Register file stand-in, with a preload path for directed setup.
  logic [63:0] rf [32] = '{default: '0};
  logic        pl_en   = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [63:0] pl_data = '0;

  always @(posedge clk) begin
    if (ifc.RegWrite) rf[ifc.WriteRegister] <= ifc.WriteData;
    if (pl_en)        rf[pl_addr]           <= pl_data;
  end

  assign ifc.rf_rd1 = rf[ifc.ReadRegister1];
  assign ifc.rf_rd2 = rf[ifc.ReadRegister2];

  int      vectors = 0;
  int      errors  = 0;
  wb_req_t mq_a[$];
  wb_req_t mq_b[$];
  bit      m_last_b = 1'b1;
  int      wr_count = 0;
  bit      grant_log[$];
  bit      log_en = 1'b0;
  bit      seen_a_full = 1'b0;
  bit      seen_b_full = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_stall(input logic [4:0] rr, input bit ga, input bit gb);
    if (rr == 5'd31) return 1'b0;
    foreach (mq_a[i]) if (mq_a[i].addr == rr && !(i == 0 && ga)) return 1'b1;
    foreach (mq_b[i]) if (mq_b[i].addr == rr && !(i == 0 && gb)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [4:0] rr, input logic [63:0] raw,
                                         input bit we, input logic [4:0] wr,
                                         input logic [63:0] wd);
    if (rr == 5'd31) return 64'd0;
    if (we && wr == rr) return wd;
    return raw;
  endfunction

  // Reference: compare this cycle's outputs, then apply the coming edge.
  always @(negedge clk) begin : monitor
    bit          ga, gb, a_acc, b_acc, e_we;
    wb_req_t     h;
    logic [4:0]  e_wr;
    logic [63:0] e_wd;
    if (ifc.RegWrite) wr_count++;
    if (!reset) begin
      mq_a.delete();
      mq_b.delete();
      m_last_b = 1'b1;
      chk("rst_regwrite", ifc.RegWrite, 0);
      chk("rst_wreg", ifc.WriteRegister, 0);
      chk("rst_wdata", ifc.WriteData, 0);
      chk("rst_a_ready", ifc.a_ready, 1);
      chk("rst_b_ready", ifc.b_ready, 1);
      chk("rst_stall1", ifc.stall1, 0);
      chk("rst_stall2", ifc.stall2, 0);
    end else begin
      ga = (mq_a.size() != 0) && (mq_b.size() == 0 || m_last_b);
      gb = (mq_b.size() != 0) && !ga;
      e_we = 1'b0;
      e_wr = '0;
      e_wd = '0;
      h    = '0;
      if (ga) h = mq_a[0];
      else if (gb) h = mq_b[0];
      if (ga || gb) begin
        e_wr = h.addr;
        e_wd = h.data;
        e_we = (h.addr != 5'd31);
      end
      chk("regwrite", ifc.RegWrite, e_we);
      chk("wreg", ifc.WriteRegister, e_wr);
      chk("wdata", ifc.WriteData, e_wd);
      chk("a_ready", ifc.a_ready, mq_a.size() < DEPTH);
      chk("b_ready", ifc.b_ready, mq_b.size() < DEPTH);
      chk("stall1", ifc.stall1, exp_stall(ifc.ReadRegister1, ga, gb));
      chk("stall2", ifc.stall2, exp_stall(ifc.ReadRegister2, ga, gb));
      chk("rdata1", ifc.ReadData1, exp_rd(ifc.ReadRegister1, rf[ifc.ReadRegister1], e_we, e_wr, e_wd));
      chk("rdata2", ifc.ReadData2, exp_rd(ifc.ReadRegister2, rf[ifc.ReadRegister2], e_we, e_wr, e_wd));
      if (log_en && (ga || gb)) grant_log.push_back(gb);
      if (mq_a.size() == DEPTH) seen_a_full = 1'b1;
      if (mq_b.size() == DEPTH) seen_b_full = 1'b1;
      a_acc = ifc.a_valid && (mq_a.size() < DEPTH);
      b_acc = ifc.b_valid && (mq_b.size() < DEPTH);
      if (ga) begin void'(mq_a.pop_front()); m_last_b = 1'b0; end
      if (gb) begin void'(mq_b.pop_front()); m_last_b = 1'b1; end
      if (a_acc) mq_a.push_back(wb_req_t'{addr: ifc.a_addr, data: ifc.a_data});
      if (b_acc) mq_b.push_back(wb_req_t'{addr: ifc.b_addr, data: ifc.b_data});
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int na, nb, w0;
    ifc.a_valid = 0; ifc.a_addr = '0; ifc.a_data = '0;
    ifc.b_valid = 0; ifc.b_addr = '0; ifc.b_data = '0;
    ifc.ReadRegister1 = '0; ifc.ReadRegister2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single write from A.
    ifc.a_valid = 1; ifc.a_addr = 5'd5; ifc.a_data = 64'h1234;
    tick();
    ifc.a_valid = 0; ifc.ReadRegister1 = 5'd5;
    #2;
    chk("single_regwrite", ifc.RegWrite, 1);
    chk("single_wreg", ifc.WriteRegister, 5);
    chk("single_wdata", ifc.WriteData, 64'h1234);
    tick(); #2;
    chk("single_rf5", rf[5], 64'h1234);
    chk("single_rdata1", ifc.ReadData1, 64'h1234);
    chk("single_idle", ifc.RegWrite, 0);
    repeat (2) tick();
    chk("single_wr_count", wr_count, 1);

    // Zero-register write from B.
    ifc.ReadRegister1 = 5'd31;
    ifc.b_valid = 1; ifc.b_addr = 5'd31; ifc.b_data = 64'hFFFF;
    tick();
    ifc.b_valid = 0;
    #2;
    chk("zero_regwrite", ifc.RegWrite, 0);
    chk("zero_wreg", ifc.WriteRegister, 31);
    chk("zero_rdata1", ifc.ReadData1, 0);
    tick(); #2;
    chk("zero_popped", ifc.WriteRegister, 0);
    chk("zero_wr_count", wr_count, 1);

    // Bypass on port 2.
    pl_en = 1; pl_addr = 5'd7; pl_data = 64'h11;
    tick();
    pl_en = 0; ifc.ReadRegister2 = 5'd7;
    #2;
    chk("byp_pre", ifc.ReadData2, 64'h11);
    ifc.a_valid = 1; ifc.a_addr = 5'd7; ifc.a_data = 64'hAB;
    tick();
    ifc.a_valid = 0;
    #2;
    chk("byp_regwrite", ifc.RegWrite, 1);
    chk("byp_rdata2", ifc.ReadData2, 64'hAB);
    chk("byp_stall2", ifc.stall2, 0);
    tick(); #2;
    chk("byp_after", ifc.ReadData2, 64'hAB);
    chk("byp_rf7", rf[7], 64'hAB);

    // Stall: A queues two writes to r9 while B wins the first slot.
    ifc.ReadRegister1 = 5'd9;
    ifc.a_valid = 1; ifc.a_addr = 5'd9;  ifc.a_data = 64'd1;
    ifc.b_valid = 1; ifc.b_addr = 5'd10; ifc.b_data = 64'h55;
    tick();
    ifc.b_valid = 0; ifc.a_data = 64'd2;
    #2;
    chk("stall_b_grant", ifc.WriteRegister, 10);
    chk("stall_c1", ifc.stall1, 1);
    tick();
    ifc.a_valid = 0;
    #2;
    chk("stall_c2_wdata", ifc.WriteData, 1);
    chk("stall_c2", ifc.stall1, 1);
    tick(); #2;
    chk("stall_c3", ifc.stall1, 0);
    chk("stall_c3_wdata", ifc.WriteData, 2);
    chk("stall_c3_rdata1", ifc.ReadData1, 2);
    tick();

    // Contention right after reset.
    reset = 0;
    tick();
    reset = 1;
    ifc.ReadRegister1 = '0; ifc.ReadRegister2 = '0;
    seen_a_full = 0; seen_b_full = 0;
    log_en = 1; na = 0; nb = 0;
    for (int cyc = 0; cyc < 60 && (na < 8 || nb < 8); cyc++) begin
      ifc.a_valid = (na < 8); ifc.a_addr = 5'(na + 1); ifc.a_data = 64'hA00 + 64'(na);
      ifc.b_valid = (nb < 8); ifc.b_addr = 5'(nb + 1); ifc.b_data = 64'hB00 + 64'(nb);
      @(negedge clk);
      if (ifc.a_valid && ifc.a_ready) na++;
      if (ifc.b_valid && ifc.b_ready) nb++;
      @(posedge clk); #1;
    end
    ifc.a_valid = 0; ifc.b_valid = 0;
    chk("cont_accepted", na + nb, 16);
    for (int c = 0; c < 20 && (mq_a.size() + mq_b.size()) != 0; c++) tick();
    chk("cont_drained", mq_a.size() + mq_b.size(), 0);
    log_en = 0;
    chk("cont_grants", grant_log.size(), 16);
    for (int i = 0; i < 4; i++) chk("cont_alternate", grant_log[i], i % 2);
    chk("cont_a_full", seen_a_full, 1);
    chk("cont_b_full", seen_b_full, 1);

    // Asynchronous reset with writes still queued.
    ifc.a_valid = 1; ifc.a_addr = 5'd20; ifc.a_data = 64'hAA;
    ifc.b_valid = 1; ifc.b_addr = 5'd21; ifc.b_data = 64'hBB;
    for (int c = 0; c < 10; c++) begin
      tick(); #2;
      if (!ifc.a_ready || !ifc.b_ready) break;
    end
    chk("arst_queued", mq_a.size() + mq_b.size(), 3);
    chk("arst_busy", ifc.RegWrite, 1);
    ifc.a_valid = 0; ifc.b_valid = 0;
    reset = 0;
    #1;
    chk("arst_regwrite", ifc.RegWrite, 0);
    chk("arst_a_ready", ifc.a_ready, 1);
    chk("arst_b_ready", ifc.b_ready, 1);
    tick();
    reset = 1;
    w0 = wr_count;
    repeat (4) tick();
    chk("arst_no_write", wr_count - w0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
